// File: rtl/rf_port_sched.sv
`default_nettype none
// ============================================================================
// Module   : rf_port_sched
// Brief    : Register-file port scheduler with a round-robin ALU/LSU write
//            arbiter and a two-stage pipelined dual-operand read path.
//            Optional feature macro: RF_PORT_SCHED_BYPASS_EN (same-cycle
//            write-to-read forwarding).
// Revision : 1.0 - initial release
// ============================================================================
module rf_port_sched #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  // writeback sources
  input  logic          alu_valid_i,
  output logic          alu_ready_o,
  input  logic [AW-1:0] alu_sel_i,
  input  logic [DW-1:0] alu_data_i,
  input  logic          lsu_valid_i,
  output logic          lsu_ready_o,
  input  logic [AW-1:0] lsu_sel_i,
  input  logic [DW-1:0] lsu_data_i,
  // decode read request / response
  input  logic          rd_req_valid_i,
  output logic          rd_req_ready_o,
  input  logic [AW-1:0] rd_sel1_i,
  input  logic [AW-1:0] rd_sel2_i,
  output logic          rd_rsp_valid_o,
  output logic [DW-1:0] rd_rsp_data1_o,
  output logic [DW-1:0] rd_rsp_data2_o,
  // register file side
  output logic          rf_wr_o,
  output logic [AW-1:0] rf_selwr_o,
  output logic [DW-1:0] rf_in_o,
  output logic          rf_rd_o,
  output logic [AW-1:0] rf_selrd1_o,
  output logic [AW-1:0] rf_selrd2_o,
  input  logic [DW-1:0] rf_out1_i,
  input  logic [DW-1:0] rf_out2_i
);

  localparam logic [AW-1:0] C_X0 = '0;

  // --------------------------------------------------------------------------
  // Write arbitration
  // --------------------------------------------------------------------------
  logic          prio_q, prio_d;
  logic          w_alu_acc;
  logic          w_lsu_acc;
  logic          w_wr_acc;
  logic          w_contend;
  logic [AW-1:0] w_wsel;
  logic [DW-1:0] w_wdata;

  assign alu_ready_o = !rst && (!lsu_valid_i || !prio_q);
  assign lsu_ready_o = !rst && (!alu_valid_i ||  prio_q);

  assign w_alu_acc = alu_valid_i && alu_ready_o;
  assign w_lsu_acc = lsu_valid_i && lsu_ready_o;
  assign w_wr_acc  = w_alu_acc || w_lsu_acc;
  assign w_contend = alu_valid_i && lsu_valid_i;

  always_comb begin
    prio_d  = prio_q;
    w_wsel  = alu_sel_i;
    w_wdata = alu_data_i;
    if (w_lsu_acc) begin
      w_wsel  = lsu_sel_i;
      w_wdata = lsu_data_i;
    end
    // Only a contested grant moves the pointer, handing it to the loser.
    if (w_contend) begin
      prio_d = w_alu_acc;
    end
  end

  // --------------------------------------------------------------------------
  // Write port registers
  // --------------------------------------------------------------------------
  logic          rf_wr_q, rf_wr_d;
  logic [AW-1:0] rf_selwr_q, rf_selwr_d;
  logic [DW-1:0] rf_in_q, rf_in_d;

  always_comb begin
    rf_wr_d    = w_wr_acc && (w_wsel != C_X0);
    rf_selwr_d = rf_selwr_q;
    rf_in_d    = rf_in_q;
    if (w_wr_acc) begin
      rf_selwr_d = w_wsel;
      rf_in_d    = w_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q     <= 1'b0;
      rf_wr_q    <= 1'b0;
      rf_selwr_q <= '0;
      rf_in_q    <= '0;
    end else begin
      prio_q     <= prio_d;
      rf_wr_q    <= rf_wr_d;
      rf_selwr_q <= rf_selwr_d;
      rf_in_q    <= rf_in_d;
    end
  end

  assign rf_wr_o    = rf_wr_q;
  assign rf_selwr_o = rf_selwr_q;
  assign rf_in_o    = rf_in_q;

  // --------------------------------------------------------------------------
  // Read pipeline: accept -> rf_rd stage -> response stage
  // --------------------------------------------------------------------------
  logic          w_rd_acc;
  logic          rf_rd_q, rf_rd_d;
  logic [AW-1:0] rf_selrd1_q, rf_selrd1_d;
  logic [AW-1:0] rf_selrd2_q, rf_selrd2_d;
  logic          rsp_valid_q, rsp_valid_d;

  assign rd_req_ready_o = !rst;
  assign w_rd_acc       = rd_req_valid_i && rd_req_ready_o;

  always_comb begin
    rf_rd_d     = w_rd_acc;
    rf_selrd1_d = rf_selrd1_q;
    rf_selrd2_d = rf_selrd2_q;
    rsp_valid_d = rf_rd_q;
    if (w_rd_acc) begin
      rf_selrd1_d = rd_sel1_i;
      rf_selrd2_d = rd_sel2_i;
    end
  end

  // Reset clears the rf_rd stage, so reads in flight never produce a response.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_rd_q     <= 1'b0;
      rf_selrd1_q <= '0;
      rf_selrd2_q <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      rf_rd_q     <= rf_rd_d;
      rf_selrd1_q <= rf_selrd1_d;
      rf_selrd2_q <= rf_selrd2_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rf_rd_o        = rf_rd_q;
  assign rf_selrd1_o    = rf_selrd1_q;
  assign rf_selrd2_o    = rf_selrd2_q;
  assign rd_rsp_valid_o = rsp_valid_q;

  // --------------------------------------------------------------------------
  // Per-operand response data
  // --------------------------------------------------------------------------
  logic [AW-1:0] w_selrd    [2];
  logic [DW-1:0] w_rf_out   [2];
  logic [DW-1:0] w_rsp_data [2];

  assign w_selrd[0]  = rf_selrd1_q;
  assign w_selrd[1]  = rf_selrd2_q;
  assign w_rf_out[0] = rf_out1_i;
  assign w_rf_out[1] = rf_out2_i;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_oper
      logic [AW-1:0] rsp_sel_q;
      logic [DW-1:0] w_src;

      // Select follows the read into the response stage, since rf_selrd may
      // already belong to the next read by then.
      always_ff @(posedge clk) begin
        if (rst) begin
          rsp_sel_q <= '0;
        end else begin
          rsp_sel_q <= w_selrd[gi];
        end
      end

`ifdef RF_PORT_SCHED_BYPASS_EN
      logic          byp_hit_q;
      logic [DW-1:0] byp_val_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          byp_hit_q <= 1'b0;
          byp_val_q <= '0;
        end else begin
          byp_hit_q <= rf_wr_q && (rf_selwr_q == w_selrd[gi]) && (rf_selwr_q != C_X0);
          byp_val_q <= rf_in_q;
        end
      end

      assign w_src = byp_hit_q ? byp_val_q : w_rf_out[gi];
`else
      assign w_src = w_rf_out[gi];
`endif

      assign w_rsp_data[gi] = (rsp_sel_q == C_X0) ? '0 : w_src;
    end
  endgenerate

  assign rd_rsp_data1_o = w_rsp_data[0];
  assign rd_rsp_data2_o = w_rsp_data[1];

endmodule
`default_nettype wire
